// File: rtl/serial_op_executor.sv
`default_nettype none
// ============================================================================
// Module      : serial_op_executor
// Description : Executes one parsed command frame (opcode plus two unsigned
//               operands) and returns the 2*WIDTH-bit result serially, MSB
//               first, behind an 8-bit response header.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_op_executor #(
  parameter int         WIDTH  = 16,
  parameter logic [7:0] HEADER = 8'b10100101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [7:0]       ctrl,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic             err
);

  // Response is header followed by the double-width result.
  localparam int SHW   = 8 + 2 * WIDTH;
  localparam int CNT_W = $clog2(SHW + 1);

  localparam logic [CNT_W-1:0] c_hdr_last = CNT_W'(7);
  localparam logic [CNT_W-1:0] c_res_last = CNT_W'(SHW - 1);
  localparam logic [CNT_W-1:0] c_mul_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_exec = 3'd1;
  localparam logic [2:0] c_st_hdr  = 3'd2;
  localparam logic [2:0] c_st_res  = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_mul = 3'd2;
  localparam logic [2:0] c_op_and = 3'd3;
  localparam logic [2:0] c_op_or  = 3'd4;
  localparam logic [2:0] c_op_xor = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [SHW-1:0]     r_shreg;
  logic               r_err;

  logic               w_legal;
  logic               w_exec_last;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_result;
  logic               w_unused_ctrl;

  // Only the low three control bits carry the opcode.
  assign w_unused_ctrl = ^ctrl[7:3];

  // Opcodes 110 and 111 are reserved.
  assign w_legal = ~(ctrl[2] & ctrl[1]);

  // Non-MUL operations finish in one cycle; MUL consumes one b bit per cycle.
  assign w_exec_last = (r_op != c_op_mul) || (r_cnt == c_mul_last);

  assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
  assign w_b_ext    = {{WIDTH{1'b0}}, r_b};
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Result selection from the latched operands / finished accumulator.
  always_comb begin
    w_result = '0;
    case (r_op)
      c_op_add: w_result = w_a_ext + w_b_ext;
      c_op_sub: w_result = w_a_ext - w_b_ext;
      c_op_mul: w_result = w_acc_next;
      c_op_and: w_result = w_a_ext & w_b_ext;
      c_op_or:  w_result = w_a_ext | w_b_ext;
      c_op_xor: w_result = w_a_ext ^ w_b_ext;
      default:  w_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (frame_valid && w_legal) w_state_next = c_st_exec;
      c_st_exec: if (w_exec_last)            w_state_next = c_st_hdr;
      c_st_hdr:  if (r_cnt == c_hdr_last)    w_state_next = c_st_res;
      c_st_res:  if (r_cnt == c_res_last)    w_state_next = c_st_done;
      c_st_done:                             w_state_next = c_st_idle;
      default:                               w_state_next = c_st_idle;
    endcase
  end

  // Output decode; err and done are masked while reset is asserted.
  always_comb begin
    busy       = 1'b0;
    dout_valid = 1'b0;
    dout       = 1'b0;
    done       = 1'b0;
    err        = r_err & ~reset;
    case (r_state)
      c_st_exec: busy = 1'b1;
      c_st_hdr, c_st_res: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        dout       = r_shreg[SHW-1];
      end
      c_st_done: begin
        busy = 1'b1;
        done = ~reset;
      end
      default: ;
    endcase
  end

  // Operand capture, shift-add multiplier and response serialiser.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_shreg  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (frame_valid && w_legal) begin
            r_a      <= input_a;
            r_b      <= input_b;
            r_op     <= ctrl[2:0];
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, input_a};
            r_mplier <= input_b;
            r_cnt    <= '0;
          end
        end
        c_st_exec: begin
          if (r_op == c_op_mul) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_one;
          end
          // Final result lands in the serialiser behind the header.
          if (w_exec_last) begin
            r_shreg <= {HEADER, w_result};
            r_cnt   <= '0;
          end
        end
        c_st_hdr, c_st_res: begin
          r_shreg <= {r_shreg[SHW-2:0], 1'b0};
          r_cnt   <= r_cnt + c_cnt_one;
        end
        default: ;
      endcase
    end
  end

  // Error pulse: illegal opcode in IDLE or any frame outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= frame_valid && ((r_state != c_st_idle) || !w_legal);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_op_executor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_op_executor
// Description : Directed self-checking bench for serial_op_executor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_op_executor;

  logic        clk;
  logic        reset;
  logic        frame_valid;
  logic [7:0]  ctrl;
  logic [15:0] input_a;
  logic [15:0] input_b;
  logic        busy;
  logic        dout;
  logic        dout_valid;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Per-frame observations, indexed by cycle offset from acceptance.
  int          first_valid;
  int          nvalid;
  int          done_cyc;
  int          done_cnt;
  int          dout_leak;
  logic [39:0] bits;
  logic [63:0] err_m;
  logic [63:0] busy_m;

  serial_op_executor #(.WIDTH(16), .HEADER(8'b10100101)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .ctrl        (ctrl),
    .input_a     (input_a),
    .input_b     (input_b),
    .busy        (busy),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a frame for the cycle ending at the next rising edge.
  task automatic send_frame(input logic [7:0] c, input logic [15:0] a, input logic [15:0] b);
    ctrl        = c;
    input_a     = a;
    input_b     = b;
    frame_valid = 1'b1;
  endtask

  // Sample ncyc cycles after acceptance; optionally inject stray frames.
  task automatic capture(input int ncyc, input int inj1, input int inj2);
    first_valid = -1;
    nvalid      = 0;
    done_cyc    = -1;
    done_cnt    = 0;
    dout_leak   = 0;
    bits        = '0;
    err_m       = '0;
    busy_m      = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin
        if (first_valid < 0) first_valid = k;
        nvalid++;
        bits = {bits[38:0], dout};
      end else if (dout !== 1'b0) begin
        dout_leak++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      err_m[k]  = err;
      busy_m[k] = busy;
      if (k == inj1 || k == inj2) begin
        ctrl        = 8'h00;
        input_a     = 16'hAAAA;
        input_b     = 16'h5555;
        frame_valid = 1'b1;
      end else begin
        frame_valid = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] res, input int first,
                             input int dcyc, input logic [63:0] exp_err);
    logic [63:0] exp_busy;
    exp_busy = '0;
    for (int k = 1; k <= dcyc; k++) exp_busy[k] = 1'b1;
    chk({tag, "_first"},  64'(first_valid), 64'(first));
    chk({tag, "_nvalid"}, 64'(nvalid), 64'd40);
    chk({tag, "_bits"},   {24'd0, bits}, {24'd0, 8'hA5, res});
    chk({tag, "_donecyc"}, 64'(done_cyc), 64'(dcyc));
    chk({tag, "_donecnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_err"},    err_m, exp_err);
    chk({tag, "_busy"},   busy_m, exp_busy);
    chk({tag, "_leak"},   64'(dout_leak), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    frame_valid = 1'b0;
    ctrl        = 8'h00;
    input_a     = 16'h0000;
    input_b     = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 64'({busy, dout, dout_valid, done, err}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs", 64'({busy, dout, dout_valid, done, err}), 64'd0);

    // ADD basic
    send_frame(8'h00, 16'h1234, 16'h0001);
    capture(60, 0, 0);
    check_frame("add1", 32'h00001235, 2, 42, 64'd0);

    // MUL full scale
    send_frame(8'h02, 16'hFFFF, 16'hFFFF);
    capture(60, 0, 0);
    check_frame("mulff", 32'hFFFE0001, 17, 57, 64'd0);

    // MUL by zero multiplicand
    send_frame(8'h02, 16'h0000, 16'hFFFF);
    capture(60, 0, 0);
    check_frame("mul0", 32'h00000000, 17, 57, 64'd0);

    // SUB wraps to all ones
    send_frame(8'h01, 16'h0001, 16'h0002);
    capture(60, 0, 0);
    check_frame("sub", 32'hFFFFFFFF, 2, 42, 64'd0);

    // ADD with carry into upper half
    send_frame(8'h00, 16'hFFFF, 16'hFFFF);
    capture(60, 0, 0);
    check_frame("addff", 32'h0001FFFE, 2, 42, 64'd0);

    // AND with ignored upper control bits set
    send_frame(8'hF3, 16'hFFFF, 16'h1234);
    capture(60, 0, 0);
    check_frame("and", 32'h00001234, 2, 42, 64'd0);

    // Illegal opcode, then an ADD two cycles later
    send_frame(8'h07, 16'h1111, 16'h2222);
    capture(2, 0, 0);
    chk("ill_err",    err_m, 64'h2);
    chk("ill_busy",   busy_m, 64'd0);
    chk("ill_nvalid", 64'(nvalid), 64'd0);
    send_frame(8'h00, 16'h0010, 16'h0020);
    capture(60, 0, 0);
    check_frame("postill", 32'h00000030, 2, 42, 64'd0);

    // OR with overruns in SEND_RES (cycle 20) and in DONE (cycle 42)
    send_frame(8'h04, 16'h00FF, 16'h0F00);
    capture(60, 20, 42);
    check_frame("ovr", 32'h00000FFF, 2, 42, (64'd1 << 21) | (64'd1 << 43));

    // Reset during SEND_RES aborts the frame
    send_frame(8'h00, 16'h1234, 16'h0001);
    capture(20, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outs", 64'({busy, dout, dout_valid, done, err}), 64'd0);
    reset = 1'b0;
    capture(6, 0, 0);
    chk("abort_busy",   busy_m, 64'd0);
    chk("abort_nvalid", 64'(nvalid), 64'd0);
    chk("abort_done",   64'(done_cnt), 64'd0);
    chk("abort_err",    err_m, 64'd0);

    // XOR after the abort
    send_frame(8'h05, 16'hF0F0, 16'hFF00);
    capture(60, 0, 0);
    check_frame("xor", 32'h00000FF0, 2, 42, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
